// File: rtl/c_reg_fifo_v1_0_pkg.sv
// Shared definitions for the c_reg_fifo core family: enable-override modes,
// per-edge operation bundle and a clog2 helper for parameter checking.
package c_reg_fifo_v1_0_pkg;

  typedef enum logic {
    C_NO_OVERRIDE = 1'b0,
    C_OVERRIDE    = 1'b1
  } override_e;

  typedef struct packed {
    logic push;
    logic pop;
    logic clr;
  } fifo_op_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/c_fifo_mem_v1_0.sv
// C_DEPTH x C_WIDTH register array: one synchronous write port, one
// asynchronous read port, no reset so it maps onto plain storage.
module c_fifo_mem_v1_0 #(
  parameter int C_WIDTH      = 16,
  parameter int C_DEPTH      = 16,
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [C_ADDR_WIDTH-1:0] wr_addr,
  input  logic [C_WIDTH-1:0]      wr_data,
  input  logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_WIDTH-1:0]      rd_data
);

  logic [C_WIDTH-1:0] mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/c_reg_fifo_v1_0.sv
// First-word-fall-through FIFO buffering the register stage output.
// Optional almost-full flag enabled by defining C_REG_FIFO_AFULL_EN.
module c_reg_fifo_v1_0
  import c_reg_fifo_v1_0_pkg::*;
#(
  parameter int C_WIDTH        = 16,
  parameter int C_DEPTH        = 16,
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_HAS_CE       = 0,
  parameter int C_HAS_SCLR     = 0,
  parameter int C_AFULL_THRESH = 12
) (
  input  logic                    CLK,
  input  logic                    ACLR,
  input  logic                    CE,
  input  logic                    SCLR,
  input  logic [C_WIDTH-1:0]      D,
  input  logic                    D_VALID,
  output logic                    D_READY,
  output logic [C_WIDTH-1:0]      Q,
  output logic                    Q_VALID,
  input  logic                    Q_READY,
  output logic [C_ADDR_WIDTH:0]   COUNT,
  output logic                    FULL,
  output logic                    EMPTY
`ifdef C_REG_FIFO_AFULL_EN
  ,
  output logic                    AFULL
`endif
);

  localparam override_e CE_MODE   = (C_HAS_CE != 0) ? C_OVERRIDE : C_NO_OVERRIDE;
  localparam override_e SCLR_MODE = (C_HAS_SCLR != 0) ? C_OVERRIDE : C_NO_OVERRIDE;
  localparam logic [C_ADDR_WIDTH:0] DEPTH_CNT = (C_ADDR_WIDTH + 1)'(C_DEPTH);

  if (C_DEPTH < 2 || C_DEPTH != (1 << C_ADDR_WIDTH) ||
      C_ADDR_WIDTH != clog2(C_DEPTH) || C_AFULL_THRESH < 0) begin : g_bad_params
    $error("c_reg_fifo_v1_0: inconsistent C_DEPTH / C_ADDR_WIDTH / C_AFULL_THRESH");
  end

  logic [C_ADDR_WIDTH-1:0] wr_ptr;
  logic [C_ADDR_WIDTH-1:0] rd_ptr;
  logic [C_ADDR_WIDTH:0]   count;
  logic [C_ADDR_WIDTH:0]   count_next;
  logic [C_WIDTH-1:0]      rd_data;
  logic                    ce_eff;
  fifo_op_t                op;

  assign ce_eff  = (CE_MODE == C_OVERRIDE) ? CE : 1'b1;
  assign op.clr  = (SCLR_MODE == C_OVERRIDE) ? SCLR : 1'b0;

  assign EMPTY   = (count == '0);
  assign FULL    = (count == DEPTH_CNT);
  assign D_READY = ~FULL;
  assign Q_VALID = ~EMPTY;
  assign COUNT   = count;

  // A synchronous clear discards any handshake that lands on the same edge.
  assign op.push = D_VALID & D_READY & ce_eff & ~op.clr;
  assign op.pop  = Q_VALID & Q_READY & ce_eff & ~op.clr;

  assign Q = Q_VALID ? rd_data : '0;

  c_fifo_mem_v1_0 #(
    .C_WIDTH      (C_WIDTH),
    .C_DEPTH      (C_DEPTH),
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_mem (
    .clk     (CLK),
    .we      (op.push),
    .wr_addr (wr_ptr),
    .wr_data (D),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    count_next = count;
    if (op.clr) begin
      count_next = '0;
    end else begin
      unique case ({op.push, op.pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (op.clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (op.push) wr_ptr <= wr_ptr + 1'b1;
        if (op.pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef C_REG_FIFO_AFULL_EN
  // Registered from the same next-count as COUNT so both move on one edge.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      AFULL <= 1'b0;
    end else begin
      AFULL <= (32'(count_next) >= 32'(C_AFULL_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_c_reg_fifo_v1_0.sv
// Scoreboard bench for c_reg_fifo_v1_0: queue-based reference model, directed
// boundary cases then randomized traffic. Covers AFULL when C_REG_FIFO_AFULL_EN.
module tb_c_reg_fifo_v1_0;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int THRESH = 12;

  logic             CLK = 1'b0;
  logic             ACLR;
  logic             CE;
  logic             SCLR;
  logic [WIDTH-1:0] D;
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic             Q_READY;
  logic [AW:0]      COUNT;
  logic             FULL;
  logic             EMPTY;
`ifdef C_REG_FIFO_AFULL_EN
  logic             AFULL;
`endif

  int compared   = 0;
  int mismatched = 0;
  int mcount     = 0;
  bit check_en   = 1'b0;
  bit m_push;
  bit m_pop;
  logic [WIDTH-1:0] exp_q [$];

  c_reg_fifo_v1_0 #(
    .C_WIDTH        (WIDTH),
    .C_DEPTH        (DEPTH),
    .C_ADDR_WIDTH   (AW),
    .C_HAS_CE       (1),
    .C_HAS_SCLR     (1),
    .C_AFULL_THRESH (THRESH)
  ) dut (
    .CLK     (CLK),
    .ACLR    (ACLR),
    .CE      (CE),
    .SCLR    (SCLR),
    .D       (D),
    .D_VALID (D_VALID),
    .D_READY (D_READY),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_READY (Q_READY),
    .COUNT   (COUNT),
    .FULL    (FULL),
    .EMPTY   (EMPTY)
`ifdef C_REG_FIFO_AFULL_EN
    ,
    .AFULL   (AFULL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [WIDTH-1:0] data,
                               input logic qr, input logic ce, input logic sclr);
    D_VALID = dv;
    D       = data;
    Q_READY = qr;
    CE      = ce;
    SCLR    = sclr;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: occupancy plus an ordered queue of words still owed.
  always @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      mcount = 0;
      exp_q.delete();
    end else if (SCLR) begin
      mcount = 0;
      exp_q.delete();
    end else if (CE) begin
      m_push = D_VALID && (mcount < DEPTH);
      m_pop  = Q_READY && (mcount > 0);
      if (m_push) exp_q.push_back(D);
      mcount = mcount + int'(m_push) - int'(m_pop);
    end
  end

  // Monitor: flags against the model every cycle, data on every accepted pop.
  always @(negedge CLK) begin
    if (check_en && !ACLR) begin
      checkOutput("count",   32'(COUNT), 32'(mcount));
      checkOutput("empty",   32'(EMPTY), 32'(mcount == 0));
      checkOutput("full",    32'(FULL), 32'(mcount == DEPTH));
      checkOutput("d_ready", 32'(D_READY), 32'(mcount != DEPTH));
      checkOutput("q_valid", 32'(Q_VALID), 32'(mcount != 0));
`ifdef C_REG_FIFO_AFULL_EN
      checkOutput("afull",   32'(AFULL), 32'(mcount >= THRESH));
`endif
      if (mcount == 0) checkOutput("q_when_empty", 32'(Q), 32'h0);
      if (Q_VALID && Q_READY && CE && !SCLR) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL q_data: pop with no word owed, got %0h", Q);
        end else begin
          checkOutput("q_data", 32'(Q), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ACLR    = 1'b1;
    CE      = 1'b1;
    SCLR    = 1'b0;
    D_VALID = 1'b0;
    D       = '0;
    Q_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_empty",   32'(EMPTY), 32'h1);
    checkOutput("rst_full",    32'(FULL), 32'h0);
    checkOutput("rst_q_valid", 32'(Q_VALID), 32'h0);
    checkOutput("rst_d_ready", 32'(D_READY), 32'h1);
    checkOutput("rst_q",       32'(Q), 32'h0);
    checkOutput("rst_count",   32'(COUNT), 32'h0);
`ifdef C_REG_FIFO_AFULL_EN
    checkOutput("rst_afull",   32'(AFULL), 32'h0);
`endif
    ACLR     = 1'b0;
    check_en = 1'b1;

    // Fill to capacity, then try one more push.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b1, 1'b0);
    checkOutput("fill_full",    32'(FULL), 32'h1);
    checkOutput("fill_d_ready", 32'(D_READY), 32'h0);
    checkOutput("fill_count",   32'(COUNT), 32'(DEPTH));
    applyStimulus(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0);
    checkOutput("overflow_ignored", 32'(COUNT), 32'(DEPTH));

    // Pop while full with D_VALID held: pop only, then push on the next edge.
    applyStimulus(1'b1, 16'h00aa, 1'b1, 1'b1, 1'b0);
    checkOutput("full_pop_count", 32'(COUNT), 32'(DEPTH - 1));
    applyStimulus(1'b1, 16'h00aa, 1'b0, 1'b1, 1'b0);
    checkOutput("refill_count", 32'(COUNT), 32'(DEPTH));

    repeat (DEPTH + 1) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(EMPTY), 32'h1);

    // Steady state at five entries; pointers wrap twice.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b0);
    repeat (40) applyStimulus(1'b1, WIDTH'($urandom), 1'b1, 1'b1, 1'b0);
    checkOutput("steady_count", 32'(COUNT), 32'h5);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Synchronous clear beats a deasserted CE.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b0);
    checkOutput("pre_sclr_count", 32'(COUNT), 32'h7);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
    checkOutput("sclr_count", 32'(COUNT), 32'h0);
    SCLR = 1'b0;
    CE   = 1'b1;

    // Asynchronous clear between edges.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b0);
    D_VALID = 1'b0;
    checkOutput("pre_aclr_count", 32'(COUNT), 32'h9);
    #1;
    ACLR = 1'b1;
    #1;
    checkOutput("aclr_empty", 32'(EMPTY), 32'h1);
    checkOutput("aclr_count", 32'(COUNT), 32'h0);
    checkOutput("aclr_q",     32'(Q), 32'h0);
    #1;
    ACLR = 1'b0;

`ifdef C_REG_FIFO_AFULL_EN
    for (int i = 1; i <= THRESH; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b0);
      checkOutput("afull_step", 32'(AFULL), 32'(i >= THRESH));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("afull_fall", 32'(AFULL), 32'h0);
    repeat (DEPTH) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
`endif

    // Randomized traffic: balanced, then push-heavy to revisit the full boundary.
    repeat (400) applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom),
                               $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
                               $urandom_range(0, 63) == 0);
    repeat (300) applyStimulus($urandom_range(0, 7) != 0, WIDTH'($urandom),
                               $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                               $urandom_range(0, 127) == 0);
    repeat (DEPTH + 2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("final_empty", 32'(EMPTY), 32'h1);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
